// File: rtl/mips_ctrl_pkg.sv
`timescale 1ns/1ps
// mips_ctrl_pkg
// Shared constants for the multicycle MIPS control path: FSM state
// encodings, ALU class codes (also consumed by the ALU controller), opcode
// values, ALU B-operand select codes, and the decoded instruction class.
// Two helper functions map an instruction class to its ALU class code and
// to its ALU B-operand select.
package mips_ctrl_pkg;

    // FSM states; 5-7 are never entered and fall back to FETCH
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } ctrlState_t;

    // ALU class codes handed to the ALU controller
    localparam logic [2:0] ALUOP_R     = 3'b000;
    localparam logic [2:0] ALUOP_ADDI  = 3'b001;
    localparam logic [2:0] ALUOP_BEQ   = 3'b010;
    localparam logic [2:0] ALUOP_BNE   = 3'b011;
    localparam logic [2:0] ALUOP_ORI   = 3'b101;
    localparam logic [2:0] ALUOP_SLTIU = 3'b110;
    localparam logic [2:0] ALUOP_MEM   = 3'b111;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct value that means "do nothing": no register write-back
    localparam logic [5:0] FUNCT_NOP = 6'b000000;

    // ALU B-operand selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    // Decoded instruction class; CLS_R doubles as the cleared value
    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_ADDI  = 3'd1,
        CLS_BEQ   = 3'd2,
        CLS_BNE   = 3'd3,
        CLS_ORI   = 3'd4,
        CLS_SLTIU = 3'd5,
        CLS_LW    = 3'd6,
        CLS_SW    = 3'd7
    } opClass_t;

    // ALU class code used while executing an instruction of class c
    function automatic logic [2:0] classAluOp(input opClass_t c);
        case (c)
            CLS_R:     return ALUOP_R;
            CLS_ADDI:  return ALUOP_ADDI;
            CLS_BEQ:   return ALUOP_BEQ;
            CLS_BNE:   return ALUOP_BNE;
            CLS_ORI:   return ALUOP_ORI;
            CLS_SLTIU: return ALUOP_SLTIU;
            default:   return ALUOP_MEM;
        endcase
    endfunction

    // ALU B operand: registers for compares/R-type, zero-extended
    // immediate for ori, sign-extended immediate for everything else
    function automatic logic [1:0] classAluSrcB(input opClass_t c);
        case (c)
            CLS_R, CLS_BEQ, CLS_BNE: return SRCB_REG;
            CLS_ORI:                 return SRCB_ZEXT;
            default:                 return SRCB_SEXT;
        endcase
    endfunction

endpackage

// File: rtl/op_class_dec.sv
`timescale 1ns/1ps
// op_class_dec
// Purely combinational opcode decoder: maps a 6-bit opcode to its
// instruction class and flags any opcode outside the supported set.
// Ports:
//   i_opcode  [5:0]  opcode from the instruction register
//   o_opClass        decoded instruction class (CLS_R when illegal)
//   o_illegal        1 when the opcode is not supported
module op_class_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output opClass_t   o_opClass,
    output logic       o_illegal
);

    // Table lookup; unknown opcodes report illegal with a harmless class
    always_comb begin
        o_opClass = CLS_R;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: o_opClass = CLS_R;
            OP_ADDI:  o_opClass = CLS_ADDI;
            OP_BEQ:   o_opClass = CLS_BEQ;
            OP_BNE:   o_opClass = CLS_BNE;
            OP_ORI:   o_opClass = CLS_ORI;
            OP_SLTIU: o_opClass = CLS_SLTIU;
            OP_LW:    o_opClass = CLS_LW;
            OP_SW:    o_opClass = CLS_SW;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// multicycle_ctrl
// Main control FSM of a multicycle MIPS subset (R, addi, beq, bne, ori,
// sltiu, lw, sw). Walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives
// the datapath strobes and mux selects. Memory waits in FETCH and MEM are
// bounded by WAIT_LIMIT cycles; on expiry the instruction is abandoned.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   opcode_i, funct_i [5:0] instruction fields, sampled in DECODE
//   zero_i                  ALU zero flag, used by branches in EXEC
//   mem_ready_i             memory access completes this cycle
//   ALUOp_o [2:0]           ALU class code for the ALU controller
//   PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o   strobes
//   RegDst_o, MemtoReg_o, ALUSrcA_o, PCSrc_o, ALUSrcB_o [1:0] mux selects
//   instr_done_o, illegal_o, timeout_o                        status pulses
//   state_o [2:0]           current state, for debug
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic [2:0] ALUOp_o,
    output logic       PCWrite_o,
    output logic       IRWrite_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       RegWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       ALUSrcA_o,
    output logic       PCSrc_o,
    output logic [1:0] ALUSrcB_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

    ctrlState_t    r_state;
    opClass_t      r_opClass;
    logic [5:0]    r_funct;
    logic [CW-1:0] r_waitCnt;

    opClass_t      w_decClass;
    logic          w_decIllegal;
    logic          w_live;
    logic          w_waiting;
    logic          w_limitHit;
    logic          w_timeout;
    logic          w_branchTaken;

    op_class_dec u_dec (
        .i_opcode  (opcode_i),
        .o_opClass (w_decClass),
        .o_illegal (w_decIllegal)
    );

    // The counter holds the number of cycles already spent waiting, so the
    // WAIT_LIMIT-th waiting cycle is the one where it equals WAIT_LIMIT-1.
    // A ready in that same cycle takes priority over the timeout.
    // Strobes that depend on inputs are held off while reset is asserted so
    // that reset looks like a quiet FETCH.
    assign w_live        = ~rst_i;
    assign w_waiting     = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready_i;
    assign w_limitHit    = (r_waitCnt == LIMIT_M1);
    assign w_timeout     = w_live && w_waiting && w_limitHit;
    assign w_branchTaken = ((r_opClass == CLS_BEQ) && zero_i) ||
                           ((r_opClass == CLS_BNE) && !zero_i);
    assign state_o       = r_state;

    // State, latched instruction fields and wait counter. The counter is
    // cleared on every cycle that is not a continued wait, which covers
    // every entry into FETCH or MEM, including a timeout re-entering FETCH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_FETCH;
            r_opClass <= CLS_R;
            r_funct   <= '0;
            r_waitCnt <= '0;
        end else begin
            r_waitCnt <= '0;
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready_i) begin
                        r_state <= ST_DECODE;
                    end else if (!w_limitHit) begin
                        r_waitCnt <= r_waitCnt + CW'(1);
                    end
                end
                ST_DECODE: begin
                    r_opClass <= w_decClass;
                    r_funct   <= funct_i;
                    r_state   <= w_decIllegal ? ST_FETCH : ST_EXEC;
                end
                ST_EXEC: begin
                    case (r_opClass)
                        CLS_BEQ, CLS_BNE: r_state <= ST_FETCH;
                        CLS_LW, CLS_SW:   r_state <= ST_MEM;
                        default:          r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        r_state <= (r_opClass == CLS_LW) ? ST_WB : ST_FETCH;
                    end else if (w_limitHit) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_waitCnt <= r_waitCnt + CW'(1);
                    end
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Output decode from the registered state; only the ready/zero/opcode
    // qualified strobes look at inputs. Everything not named in a state
    // stays 0.
    always_comb begin
        ALUOp_o      = ALUOP_R;
        PCWrite_o    = 1'b0;
        IRWrite_o    = 1'b0;
        MemRead_o    = 1'b0;
        MemWrite_o   = 1'b0;
        RegWrite_o   = 1'b0;
        RegDst_o     = 1'b0;
        MemtoReg_o   = 1'b0;
        ALUSrcA_o    = 1'b0;
        PCSrc_o      = 1'b0;
        ALUSrcB_o    = SRCB_REG;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        timeout_o    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = SRCB_FOUR;
                ALUOp_o   = ALUOP_MEM;
                if (mem_ready_i && w_live) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                end
                timeout_o = w_timeout;
            end
            ST_DECODE: begin
                illegal_o = w_decIllegal;
            end
            ST_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = classAluOp(r_opClass);
                ALUSrcB_o = classAluSrcB(r_opClass);
                if ((r_opClass == CLS_BEQ) || (r_opClass == CLS_BNE)) begin
                    instr_done_o = 1'b1;
                    if (w_branchTaken) begin
                        PCWrite_o = 1'b1;
                        PCSrc_o   = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                MemRead_o    = (r_opClass == CLS_LW);
                MemWrite_o   = (r_opClass == CLS_SW) && !w_timeout;
                instr_done_o = (r_opClass == CLS_SW) && mem_ready_i;
                timeout_o    = w_timeout;
            end
            ST_WB: begin
                RegWrite_o   = !((r_opClass == CLS_R) && (r_funct == FUNCT_NOP));
                RegDst_o     = (r_opClass == CLS_R);
                MemtoReg_o   = (r_opClass == CLS_LW);
                instr_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
// tb_multicycle_ctrl
// Directed scoreboard bench. Each applied cycle pushes its hand-computed
// output vector into a queue; a monitor on the falling edge pops and
// compares against everything the controller drives.
// Vector layout: {state[2:0], ALUOp[2:0], ALUSrcB[1:0], ALUSrcA, bits[10:0]}
// with bits = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst,
//              MemtoReg, PCSrc, instr_done, illegal, timeout}.
module tb_multicycle_ctrl;

    localparam logic [10:0] B_PCW  = 11'h400;
    localparam logic [10:0] B_IRW  = 11'h200;
    localparam logic [10:0] B_MRD  = 11'h100;
    localparam logic [10:0] B_MWR  = 11'h080;
    localparam logic [10:0] B_RGW  = 11'h040;
    localparam logic [10:0] B_RDS  = 11'h020;
    localparam logic [10:0] B_M2R  = 11'h010;
    localparam logic [10:0] B_PCS  = 11'h008;
    localparam logic [10:0] B_DONE = 11'h004;
    localparam logic [10:0] B_ILL  = 11'h002;
    localparam logic [10:0] B_TO   = 11'h001;

    localparam logic [5:0] OPC_R     = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BAD   = 6'b111111;

    // Common expected vectors
    localparam logic [19:0] V_FETCH_WAIT = {3'd0, 3'b111, 2'b01, 1'b0, B_MRD};
    localparam logic [19:0] V_FETCH_GO   = {3'd0, 3'b111, 2'b01, 1'b0, B_PCW | B_IRW | B_MRD};
    localparam logic [19:0] V_FETCH_TO   = {3'd0, 3'b111, 2'b01, 1'b0, B_MRD | B_TO};
    localparam logic [19:0] V_DECODE     = {3'd1, 3'b000, 2'b00, 1'b0, 11'h000};
    localparam logic [19:0] V_EXEC_MEM   = {3'd2, 3'b111, 2'b10, 1'b1, 11'h000};
    localparam logic [19:0] V_WB_IMM     = {3'd4, 3'b000, 2'b00, 1'b0, B_RGW | B_DONE};

    logic       clk_i;
    logic       rst_i;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic [2:0] ALUOp_o;
    logic       PCWrite_o;
    logic       IRWrite_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       RegWrite_o;
    logic       RegDst_o;
    logic       MemtoReg_o;
    logic       ALUSrcA_o;
    logic       PCSrc_o;
    logic [1:0] ALUSrcB_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic       timeout_o;
    logic [2:0] state_o;

    string       nameQ[$];
    logic [19:0] vecQ[$];
    int          numChecks = 0;
    int          numFails  = 0;

    multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .opcode_i     (opcode_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .ALUOp_o      (ALUOp_o),
        .PCWrite_o    (PCWrite_o),
        .IRWrite_o    (IRWrite_o),
        .MemRead_o    (MemRead_o),
        .MemWrite_o   (MemWrite_o),
        .RegWrite_o   (RegWrite_o),
        .RegDst_o     (RegDst_o),
        .MemtoReg_o   (MemtoReg_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .PCSrc_o      (PCSrc_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o),
        .timeout_o    (timeout_o),
        .state_o      (state_o)
    );

    // 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs shortly after the rising edge and record
    // what the controller must show during that cycle
    task automatic applyStimulus(input string name, input logic rst, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z, input logic rdy,
                                 input logic [19:0] expVec);
        rst_i       = rst;
        opcode_i    = op;
        funct_i     = fn;
        zero_i      = z;
        mem_ready_i = rdy;
        nameQ.push_back(name);
        vecQ.push_back(expVec);
        @(posedge clk_i);
        #1;
    endtask

    // Pop the oldest expectation and compare against the live outputs
    task automatic checkOutput();
        string       name;
        logic [19:0] expVec;
        logic [19:0] actVec;
        name   = nameQ.pop_front();
        expVec = vecQ.pop_front();
        actVec = {state_o, ALUOp_o, ALUSrcB_o, ALUSrcA_o,
                  PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o,
                  RegDst_o, MemtoReg_o, PCSrc_o, instr_done_o, illegal_o, timeout_o};
        numChecks++;
        if (actVec !== expVec) begin
            numFails++;
            $display("[TB] FAIL %s: got %05h required %05h (state %0d vs %0d)",
                     name, actVec, expVec, actVec[19:17], expVec[19:17]);
        end
    endtask

    // Monitor: samples mid-cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk_i);
            if (vecQ.size() > 0) checkOutput();
        end
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d checks queued", vecQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        opcode_i    = '0;
        funct_i     = '0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset looks like FETCH with strobes held off even with ready high
        applyStimulus("reset", 1'b1, OPC_R, 6'd0, 1'b0, 1'b1, V_FETCH_WAIT);

        // addi: 0,1,2,4
        applyStimulus("addi fetch",  1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("addi decode", 1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("addi exec",   1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, {3'd2, 3'b001, 2'b10, 1'b1, 11'h000});
        applyStimulus("addi wb",     1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_WB_IMM);

        // Branches, all four zero/class combinations
        applyStimulus("beq z1 fetch",  1'b0, OPC_BEQ, 6'd0, 1'b1, 1'b1, V_FETCH_GO);
        applyStimulus("beq z1 decode", 1'b0, OPC_BEQ, 6'd0, 1'b1, 1'b1, V_DECODE);
        applyStimulus("beq z1 exec",   1'b0, OPC_BEQ, 6'd0, 1'b1, 1'b1, {3'd2, 3'b010, 2'b00, 1'b1, B_PCW | B_PCS | B_DONE});
        applyStimulus("bne z1 fetch",  1'b0, OPC_BNE, 6'd0, 1'b1, 1'b1, V_FETCH_GO);
        applyStimulus("bne z1 decode", 1'b0, OPC_BNE, 6'd0, 1'b1, 1'b1, V_DECODE);
        applyStimulus("bne z1 exec",   1'b0, OPC_BNE, 6'd0, 1'b1, 1'b1, {3'd2, 3'b011, 2'b00, 1'b1, B_DONE});
        applyStimulus("bne z0 fetch",  1'b0, OPC_BNE, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("bne z0 decode", 1'b0, OPC_BNE, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("bne z0 exec",   1'b0, OPC_BNE, 6'd0, 1'b0, 1'b1, {3'd2, 3'b011, 2'b00, 1'b1, B_PCW | B_PCS | B_DONE});
        applyStimulus("beq z0 fetch",  1'b0, OPC_BEQ, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("beq z0 decode", 1'b0, OPC_BEQ, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("beq z0 exec",   1'b0, OPC_BEQ, 6'd0, 1'b0, 1'b1, {3'd2, 3'b010, 2'b00, 1'b1, B_DONE});

        // R-type add and nop
        applyStimulus("radd fetch",  1'b0, OPC_R, 6'b100000, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("radd decode", 1'b0, OPC_R, 6'b100000, 1'b0, 1'b1, V_DECODE);
        applyStimulus("radd exec",   1'b0, OPC_R, 6'b100000, 1'b0, 1'b1, {3'd2, 3'b000, 2'b00, 1'b1, 11'h000});
        applyStimulus("radd wb",     1'b0, OPC_R, 6'b100000, 1'b0, 1'b1, {3'd4, 3'b000, 2'b00, 1'b0, B_RGW | B_RDS | B_DONE});
        applyStimulus("nop fetch",   1'b0, OPC_R, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("nop decode",  1'b0, OPC_R, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("nop exec",    1'b0, OPC_R, 6'd0, 1'b0, 1'b1, {3'd2, 3'b000, 2'b00, 1'b1, 11'h000});
        applyStimulus("nop wb",      1'b0, OPC_R, 6'd0, 1'b0, 1'b1, {3'd4, 3'b000, 2'b00, 1'b0, B_RDS | B_DONE});

        // ori and sltiu
        applyStimulus("ori fetch",    1'b0, OPC_ORI, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("ori decode",   1'b0, OPC_ORI, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("ori exec",     1'b0, OPC_ORI, 6'd0, 1'b0, 1'b1, {3'd2, 3'b101, 2'b11, 1'b1, 11'h000});
        applyStimulus("ori wb",       1'b0, OPC_ORI, 6'd0, 1'b0, 1'b1, V_WB_IMM);
        applyStimulus("sltiu fetch",  1'b0, OPC_SLTIU, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("sltiu decode", 1'b0, OPC_SLTIU, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("sltiu exec",   1'b0, OPC_SLTIU, 6'd0, 1'b0, 1'b1, {3'd2, 3'b110, 2'b10, 1'b1, 11'h000});
        applyStimulus("sltiu wb",     1'b0, OPC_SLTIU, 6'd0, 1'b0, 1'b1, V_WB_IMM);

        // lw with three not-ready cycles in MEM
        applyStimulus("lw fetch",  1'b0, OPC_LW, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("lw decode", 1'b0, OPC_LW, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("lw exec",   1'b0, OPC_LW, 6'd0, 1'b0, 1'b0, V_EXEC_MEM);
        for (int i = 0; i < 3; i++)
            applyStimulus("lw mem wait", 1'b0, OPC_LW, 6'd0, 1'b0, 1'b0, {3'd3, 3'b000, 2'b00, 1'b0, B_MRD});
        applyStimulus("lw mem ready", 1'b0, OPC_LW, 6'd0, 1'b0, 1'b1, {3'd3, 3'b000, 2'b00, 1'b0, B_MRD});
        applyStimulus("lw wb",        1'b0, OPC_LW, 6'd0, 1'b0, 1'b1, {3'd4, 3'b000, 2'b00, 1'b0, B_RGW | B_M2R | B_DONE});

        // sw completing immediately
        applyStimulus("sw fetch",  1'b0, OPC_SW, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("sw decode", 1'b0, OPC_SW, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("sw exec",   1'b0, OPC_SW, 6'd0, 1'b0, 1'b1, V_EXEC_MEM);
        applyStimulus("sw mem",    1'b0, OPC_SW, 6'd0, 1'b0, 1'b1, {3'd3, 3'b000, 2'b00, 1'b0, B_MWR | B_DONE});

        // sw timing out in MEM: 15th waiting cycle pulses timeout, no write
        applyStimulus("swto fetch",  1'b0, OPC_SW, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("swto decode", 1'b0, OPC_SW, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("swto exec",   1'b0, OPC_SW, 6'd0, 1'b0, 1'b0, V_EXEC_MEM);
        for (int i = 0; i < 14; i++)
            applyStimulus("swto mem wait", 1'b0, OPC_SW, 6'd0, 1'b0, 1'b0, {3'd3, 3'b000, 2'b00, 1'b0, B_MWR});
        applyStimulus("swto mem timeout", 1'b0, OPC_SW, 6'd0, 1'b0, 1'b0, {3'd3, 3'b000, 2'b00, 1'b0, B_TO});

        // Illegal opcode
        applyStimulus("ill fetch",  1'b0, OPC_BAD, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("ill decode", 1'b0, OPC_BAD, 6'd0, 1'b0, 1'b0, {3'd1, 3'b000, 2'b00, 1'b0, B_ILL});

        // FETCH timeout after 15 cycles, then ready arriving on the limit cycle wins
        for (int i = 0; i < 14; i++)
            applyStimulus("fto wait", 1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b0, V_FETCH_WAIT);
        applyStimulus("fto timeout", 1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b0, V_FETCH_TO);
        for (int i = 0; i < 14; i++)
            applyStimulus("fto rewait", 1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b0, V_FETCH_WAIT);
        applyStimulus("ready at limit", 1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("limit decode",   1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("limit exec",     1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, {3'd2, 3'b001, 2'b10, 1'b1, 11'h000});
        applyStimulus("limit wb",       1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_WB_IMM);

        // Reset in the middle of a lw MEM wait abandons the load
        applyStimulus("rlw fetch",    1'b0, OPC_LW, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("rlw decode",   1'b0, OPC_LW, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("rlw exec",     1'b0, OPC_LW, 6'd0, 1'b0, 1'b0, V_EXEC_MEM);
        applyStimulus("rlw mem wait", 1'b0, OPC_LW, 6'd0, 1'b0, 1'b0, {3'd3, 3'b000, 2'b00, 1'b0, B_MRD});
        applyStimulus("rlw reset",    1'b1, OPC_LW, 6'd0, 1'b0, 1'b1, V_FETCH_WAIT);
        applyStimulus("rlw after 1",  1'b0, OPC_LW, 6'd0, 1'b0, 1'b0, V_FETCH_WAIT);
        applyStimulus("rlw after 2",  1'b0, OPC_LW, 6'd0, 1'b0, 1'b0, V_FETCH_WAIT);
        applyStimulus("post fetch",   1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_FETCH_GO);
        applyStimulus("post decode",  1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_DECODE);
        applyStimulus("post exec",    1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, {3'd2, 3'b001, 2'b10, 1'b1, 11'h000});
        applyStimulus("post wb",      1'b0, OPC_ADDI, 6'd0, 1'b0, 1'b1, V_WB_IMM);

        // Let the monitor drain, bounded
        repeat (3) @(negedge clk_i);
        if (vecQ.size() != 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", vecQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: WAIT_LIMIT, default 15, is the maximum number of cycles spent waiting for mem_ready_i before timeout.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 opcode_i  input  6  instruction opcode from the instruction register; sampled in DECODE.
REQ-005 funct_i  input  6  R-type function field; sampled in DECODE.
REQ-006 zero_i  input  1  ALU zero flag; sampled in EXEC.
REQ-007 mem_ready_i  input  1  memory access complete this cycle.
REQ-008 ALUOp_o  output  3  ALU class code for the ALU controller.
REQ-009 PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o  output  1 each  single-cycle write/access strobes.
REQ-010 RegDst_o, MemtoReg_o, ALUSrcA_o, PCSrc_o  output  1 each  datapath mux selects.
REQ-011 ALUSrcB_o  output  2  ALU B select: 00 reg, 01 const 4, 10 sign-extended imm, 11 zero-extended imm.
REQ-012 instr_done_o, illegal_o, timeout_o  output  1 each  one-cycle status pulses.
REQ-013 state_o  output  3  current FSM state, for debug.

Function
REQ-014 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; 5-7 are unreachable and SHALL go to FETCH.
REQ-015 ALUOp_o encoding (shared constants): R=000, addi=001, beq=010, bne=011, ori=101, sltiu=110, lw/sw=111.
REQ-016 Decode: 000000 R, 001000 addi, 000100 beq, 000101 bne, 001101 ori, 001011 sltiu, 100011 lw, 101011 sw; all others illegal.
REQ-017 FETCH: MemRead_o=1, ALUSrcA_o=0, ALUSrcB_o=01, ALUOp_o=111; on mem_ready_i: IRWrite_o=1, PCWrite_o=1, PCSrc_o=0, go to DECODE; else stay.
REQ-018 DECODE: latch opcode class and funct into internal registers; illegal opcode pulses illegal_o and returns to FETCH; else go to EXEC.
REQ-019 EXEC: ALUSrcA_o=1, ALUOp_o per class, ALUSrcB_o=00 for R/beq/bne, 10 for addi/lw/sw/sltiu, 11 for ori.
REQ-020 EXEC branch: PCWrite_o=1 and PCSrc_o=1 when (beq and zero_i=1) or (bne and zero_i=0); pulse instr_done_o; go to FETCH.
REQ-021 EXEC lw/sw goes to MEM; all other classes go to WB.
REQ-022 MEM: lw asserts MemRead_o, sw asserts MemWrite_o; on mem_ready_i, lw goes to WB, sw pulses instr_done_o and goes to FETCH.
REQ-023 WB: RegWrite_o=1, except R-type with funct 000000 (nop), which gives RegWrite_o=0; RegDst_o=1 for R only; MemtoReg_o=1 for lw only; pulse instr_done_o; go to FETCH.
REQ-024 Latency with mem_ready_i always high: branch 3 cycles, R/addi/ori/sltiu/sw 4, lw 5.
REQ-025 A wait counter SHALL clear on entering FETCH or MEM and increment each waiting cycle.
REQ-026 Timeout: reaching WAIT_LIMIT without mem_ready_i SHALL pulse timeout_o, suppress all write strobes, and go to FETCH.
REQ-027 mem_ready_i arriving in the same cycle as the limit SHALL win, with no timeout.
REQ-028 All strobes and unlisted selects SHALL be 0 in states where they are not named.
REQ-029 Outputs SHALL be Moore, except the zero_i/mem_ready_i-qualified strobes.

Reset
REQ-030 rst_i SHALL immediately force FETCH, clear the wait counter and latched class, and drive all outputs per FETCH with no strobes.
REQ-031 Assertion mid-instruction SHALL abandon it with no further writes; the first rising edge after release evaluates FETCH.

Structure
REQ-032 State encodings, ALUOp codes and opcode constants SHALL live in shared package mips_ctrl_pkg, which is also used by the ALU controller.
REQ-033 The opcode-to-class decode SHALL be a combinational sub-module, op_class_dec.

Verification
REQ-034 addi (001000), mem_ready_i=1 -> states 0,1,2,4, ALUOp 001, ALUSrcB 10, RegWrite on cycle 4, instr_done_o on cycle 4.
REQ-035 beq with zero_i=1, then bne with zero_i=1 -> first gives PCWrite+PCSrc in EXEC; second gives no PCWrite; each done in 3 cycles.
REQ-036 lw with mem_ready_i low 3 cycles in MEM -> stays in MEM 4 cycles, then WB with MemtoReg=1 and RegWrite=1.
REQ-037 mem_ready_i held low in FETCH, WAIT_LIMIT=15 -> timeout_o after 15 cycles, no IRWrite.
REQ-038 opcode 111111 -> illegal_o in DECODE, back to FETCH, no RegWrite.
REQ-039 rst_i asserted during lw MEM -> same-cycle state_o=0, MemRead from FETCH only, and no RegWrite afterwards.
